i2c_slave_rx: RTL and testbench

Single-address I2C responder (target) for the dual-master bus: watches the shared SCL/SDA lines, detects START/STOP, matches the 7-bit address against its own, ACKs, then accepts write bytes or returns read bytes. Serves as the bus endpoint the masters and arbiter address (default 7'b1010101). Oversamples the bus with the system clock; SDA is driven open-drain via an output enable.

---
 rtl/i2c_slave_rx_if.sv | 22 ++
 rtl/i2c_slave_rx.sv | 172 +++++++++++++++++
 tb/tb_i2c_slave_rx.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_slave_rx_if.sv
// Bus-side and user-side signals of the single-address I2C target.
interface i2c_slave_rx_if;
  logic       scl_in;
  logic       sda_in;
  logic       sda_oe;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic [7:0] tx_data;
  logic       tx_req;
  logic       addr_hit;
  logic       busy;

  modport slave (
    input  scl_in, sda_in, tx_data,
    output sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy
  );

  modport master (
    output scl_in, sda_in, tx_data,
    input  sda_oe, rx_data, rx_valid, tx_req, addr_hit, busy
  );
endinterface

// File: rtl/i2c_slave_rx.sv
// Oversampling single-address I2C target: ACKs its address, accepts writes, serves reads.
// Optional macro I2C_SLAVE_GCALL_EN also ACKs the general-call write address 7'b0000000.
module i2c_slave_rx #(
  parameter logic [6:0] SLAVE_ADDR = 7'b1010101
) (
  input logic            clk,
  input logic            reset,
  i2c_slave_rx_if.slave  bus
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WRITE, WRITE_ACK, READ, READ_ACK, WAIT_STOP
  } state_t;

  state_t     state;
  logic [1:0] scl_sync, sda_sync;
  logic       scl_d, sda_d;
  logic [2:0] bit_cnt;
  logic [6:0] shift;
  logic [7:0] tx_shift;
  logic       rw;
  logic       ack_phase;

  logic scl, sda, scl_rise, scl_fall, sda_rise, sda_fall, start_c, stop_c;
  logic [7:0] byte_c;
  logic       match_c;

  // Two-flop synchronisers plus one delay flop per line for edge detection
  always_ff @(posedge clk) begin
    if (reset) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
      scl_d    <= 1'b1;
      sda_d    <= 1'b1;
    end else begin
      scl_sync <= {scl_sync[0], bus.scl_in};
      sda_sync <= {sda_sync[0], bus.sda_in};
      scl_d    <= scl_sync[1];
      sda_d    <= sda_sync[1];
    end
  end

  assign scl      = scl_sync[1];
  assign sda      = sda_sync[1];
  assign scl_rise = scl & ~scl_d;
  assign scl_fall = ~scl & scl_d;
  assign sda_rise = sda & ~sda_d;
  assign sda_fall = ~sda & sda_d;
  // SCL must be stable high on both samples, so a joint SDA/SCL change is data
  assign start_c  = sda_fall & scl & scl_d;
  assign stop_c   = sda_rise & scl & scl_d;
  assign byte_c   = {shift, sda};

`ifdef I2C_SLAVE_GCALL_EN
  assign match_c = (byte_c[7:1] == SLAVE_ADDR) || (byte_c == 8'h00);
`else
  assign match_c = (byte_c[7:1] == SLAVE_ADDR);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= 3'd0;
      shift        <= 7'd0;
      tx_shift     <= 8'd0;
      rw           <= 1'b0;
      ack_phase    <= 1'b0;
      bus.sda_oe   <= 1'b0;
      bus.rx_data  <= 8'h00;
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.addr_hit <= 1'b0;
      bus.busy     <= 1'b0;
    end else begin
      bus.rx_valid <= 1'b0;
      bus.tx_req   <= 1'b0;
      bus.addr_hit <= 1'b0;
      if (start_c) begin
        state      <= ADDR;
        bit_cnt    <= 3'd7;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else if (stop_c) begin
        state      <= IDLE;
        ack_phase  <= 1'b0;
        bus.sda_oe <= 1'b0;
        bus.busy   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift <= byte_c[6:0];
            if (bit_cnt == 3'd0) begin
              rw        <= sda;
              ack_phase <= 1'b0;
              state     <= match_c ? ADDR_ACK : WAIT_STOP;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          // First fall drives the ACK low, second fall hands SDA to the data phase
          ADDR_ACK, WRITE_ACK: if (scl_fall) begin
            if (!ack_phase) begin
              ack_phase  <= 1'b1;
              bus.sda_oe <= 1'b1;
              if (state == ADDR_ACK) begin
                bus.addr_hit <= 1'b1;
                bus.busy     <= 1'b1;
              end
            end else begin
              ack_phase <= 1'b0;
              bit_cnt   <= 3'd7;
              if (state == ADDR_ACK && rw) begin
                tx_shift   <= bus.tx_data;
                bus.tx_req <= 1'b1;
                bus.sda_oe <= ~bus.tx_data[7];
                state      <= READ;
              end else begin
                bus.sda_oe <= 1'b0;
                state      <= WRITE;
              end
            end
          end
          WRITE: if (scl_rise) begin
            shift <= byte_c[6:0];
            if (bit_cnt == 3'd0) begin
              bus.rx_data  <= byte_c;
              bus.rx_valid <= 1'b1;
              ack_phase    <= 1'b0;
              state        <= WRITE_ACK;
            end else begin
              bit_cnt <= bit_cnt - 3'd1;
            end
          end
          // Bit 7 is already on the bus; shift out bits 6..0, then release for the master ACK
          READ: if (scl_fall) begin
            if (bit_cnt == 3'd0) begin
              bus.sda_oe <= 1'b0;
              ack_phase  <= 1'b0;
              state      <= READ_ACK;
            end else begin
              bus.sda_oe <= ~tx_shift[6];
              tx_shift   <= {tx_shift[6:0], 1'b0};
              bit_cnt    <= bit_cnt - 3'd1;
            end
          end
          READ_ACK: begin
            if (!ack_phase) begin
              if (scl_rise) begin
                if (sda) begin
                  bus.busy <= 1'b0;
                  state    <= WAIT_STOP;
                end else begin
                  tx_shift   <= bus.tx_data;
                  bus.tx_req <= 1'b1;
                  ack_phase  <= 1'b1;
                end
              end
            end else if (scl_fall) begin
              bus.sda_oe <= ~tx_shift[7];
              ack_phase  <= 1'b0;
              bit_cnt    <= 3'd7;
              state      <= READ;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_rx.sv
// Bench acting as an I2C master against i2c_slave_rx, checked against a transaction-level model.
module tb_i2c_slave_rx;
  localparam int H = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic sda_m = 1'b1;

  i2c_slave_rx_if bus();
  i2c_slave_rx dut (.clk(clk), .reset(reset), .bus(bus));

  assign bus.sda_in = sda_m & ~bus.sda_oe;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic exp_oe = 1'b0;
  bit   chk_oe = 1'b0;
  logic exp_busy = 1'b0;
  bit   chk_busy = 1'b0;
  int   hi_cnt = 0;
  int   n_rx = 0, n_tx = 0, n_hit = 0;
  logic prv_rx = 1'b0, prv_tx = 1'b0, prv_hit = 1'b0;
  logic [7:0] rxq[$];
  logic [7:0] xd[4];
  logic [7:0] rd_got[4];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit addr_match(input logic [6:0] a, input logic rw);
    if (a == 7'h55) return 1'b1;
`ifdef I2C_SLAVE_GCALL_EN
    if (a == 7'h00 && !rw) return 1'b1;
`endif
    return 1'b0;
  endfunction

  // Per-cycle compare of SDA drive and busy in settled SCL-high windows, plus pulse tracking
  always @(negedge clk) begin
    if (bus.scl_in === 1'b1) hi_cnt++; else hi_cnt = 0;
    if (!reset) begin
      if (hi_cnt >= 6) begin
        if (chk_oe)   check("sda_oe", bus.sda_oe, exp_oe);
        if (chk_busy) check("busy", bus.busy, exp_busy);
      end
      if (bus.rx_valid) begin
        check("rx_valid_width", prv_rx, 0);
        n_rx++;
        rxq.push_back(bus.rx_data);
      end
      if (bus.tx_req) begin
        check("tx_req_width", prv_tx, 0);
        n_tx++;
      end
      if (bus.addr_hit) begin
        check("addr_hit_width", prv_hit, 0);
        n_hit++;
      end
    end
    prv_rx  = bus.rx_valid;
    prv_tx  = bus.tx_req;
    prv_hit = bus.addr_hit;
  end

  initial begin
    #700000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic clk_bit(input logic b, input logic eoe, output logic line);
    repeat (H/2) @(negedge clk);
    sda_m = b;
    repeat (H/2) @(negedge clk);
    exp_oe = eoe; chk_oe = 1'b1; bus.scl_in = 1'b1;
    repeat (H) @(negedge clk);
    line = bus.sda_in; chk_oe = 1'b0; bus.scl_in = 1'b0;
  endtask

  task automatic bus_start();
    chk_oe = 1'b0; chk_busy = 1'b0;
    repeat (H/2) @(negedge clk);
    sda_m = 1'b1;
    repeat (H/2) @(negedge clk);
    bus.scl_in = 1'b1;
    repeat (H) @(negedge clk);
    sda_m = 1'b0;
    repeat (H) @(negedge clk);
    bus.scl_in = 1'b0;
  endtask

  task automatic bus_stop();
    chk_oe = 1'b0; chk_busy = 1'b0;
    repeat (H/2) @(negedge clk);
    sda_m = 1'b0;
    repeat (H/2) @(negedge clk);
    bus.scl_in = 1'b1;
    repeat (H) @(negedge clk);
    sda_m = 1'b1;
    repeat (H) @(negedge clk);
  endtask

  task automatic wr_byte(input logic [7:0] b, input bit ack_exp, input bit busy_bits, output bit got);
    logic line;
    exp_busy = busy_bits; chk_busy = 1'b1;
    for (int i = 7; i >= 0; i--) clk_bit(b[i], 1'b0, line);
    exp_busy = ack_exp;
    clk_bit(1'b1, ack_exp, line);
    got = ~line;
  endtask

  task automatic rd_byte(input logic [7:0] exp_b, input bit acked, input bit m_ack,
                         input logic [7:0] next_tx, output logic [7:0] got);
    logic line;
    got = 8'h00;
    exp_busy = acked; chk_busy = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clk_bit(1'b1, ~exp_b[i], line);
      got[i] = line;
    end
    bus.tx_data = next_tx;
    chk_busy = m_ack;
    clk_bit(~m_ack, 1'b0, line);
  endtask

  // One transaction against the model: xd[] holds write data or the tx_data sequence
  task automatic do_xfer(input logic [6:0] addr, input logic rw, input int n, input bit do_stop);
    bit acked;
    bit got;
    int rx0, tx0, h0;
    logic [7:0] rb;
    acked = addr_match(addr, rw);
    rx0 = n_rx; tx0 = n_tx; h0 = n_hit;
    rxq.delete();
    if (rw) bus.tx_data = xd[0];
    bus_start();
    wr_byte({addr, rw}, acked, 1'b0, got);
    check("addr_ack", got, acked);
    for (int k = 0; k < n; k++) begin
      if (!rw) begin
        wr_byte(xd[k], acked, acked, got);
        check("data_ack", got, acked);
      end else begin
        rd_byte(acked ? xd[k] : 8'hFF, acked, k < n - 1, (k + 1 < n) ? xd[k+1] : 8'h00, rb);
        rd_got[k] = rb;
        check("rd_byte", rb, acked ? xd[k] : 8'hFF);
      end
    end
    if (do_stop) begin
      bus_stop();
      check("busy_after_stop", bus.busy, 0);
      check("sda_oe_after_stop", bus.sda_oe, 0);
    end
    check("addr_hit_cnt", n_hit - h0, acked ? 1 : 0);
    check("rx_valid_cnt", n_rx - rx0, (acked && !rw) ? n : 0);
    check("tx_req_cnt", n_tx - tx0, (acked && rw) ? n : 0);
    if (acked && !rw)
      for (int k = 0; k < n; k++)
        if (k < rxq.size()) check("rx_byte", rxq[k], xd[k]);
  endtask

  initial begin
    logic line;
    bit got;
    int rx0;
    int sel, n;
    logic [6:0] a;
    logic rw;
    bit st;

    bus.scl_in = 1'b1;
    bus.tx_data = 8'h00;
    repeat (5) @(negedge clk);
    check("rst_sda_oe", bus.sda_oe, 0);
    check("rst_rx_data", bus.rx_data, 8'h00);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_req", bus.tx_req, 0);
    check("rst_addr_hit", bus.addr_hit, 0);
    check("rst_busy", bus.busy, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Write 0xAA to 0x55
    xd[0] = 8'hAA;
    do_xfer(7'h55, 1'b0, 1, 1'b1);
    check("t1_rx_data", bus.rx_data, 8'hAA);

    // Read 0x3C from 0x55, master NACKs
    xd[0] = 8'h3C;
    do_xfer(7'h55, 1'b1, 1, 1'b1);
    check("t2_rd_lit", rd_got[0], 8'h3C);

    // Foreign address 0x2A
    xd[0] = 8'h77;
    do_xfer(7'h2A, 1'b0, 1, 1'b1);
    check("t3_rx_data_kept", bus.rx_data, 8'hAA);

    // Two-byte write, repeated START, two-byte read
    xd[0] = 8'h12; xd[1] = 8'h34;
    do_xfer(7'h55, 1'b0, 2, 1'b0);
    check("t4_rx_data", bus.rx_data, 8'h34);
    xd[0] = 8'h5E; xd[1] = 8'h99;
    do_xfer(7'h55, 1'b1, 2, 1'b1);
    check("t4_rd_lit", rd_got[1], 8'h99);

    // Reset in the low phase of data bit 4
    rx0 = n_rx;
    bus_start();
    wr_byte(8'hAA, 1'b1, 1'b0, got);
    check("t5_addr_ack", got, 1);
    exp_busy = 1'b1; chk_busy = 1'b1;
    for (int i = 7; i >= 5; i--) clk_bit(1'b1, 1'b0, line);
    chk_busy = 1'b0;
    repeat (H/2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t5_rst_sda_oe", bus.sda_oe, 0);
    check("t5_rst_busy", bus.busy, 0);
    check("t5_rst_rx_data", bus.rx_data, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    exp_busy = 1'b0; chk_busy = 1'b1;
    for (int i = 4; i >= 0; i--) clk_bit(1'b0, 1'b0, line);
    clk_bit(1'b1, 1'b0, line);
    check("t5_no_ack", line, 1);
    bus_stop();
    check("t5_no_rx_valid", n_rx - rx0, 0);
    xd[0] = 8'h81;
    do_xfer(7'h55, 1'b0, 1, 1'b1);
    check("t5_recover", bus.rx_data, 8'h81);

    // General call
    xd[0] = 8'h5A;
    do_xfer(7'h00, 1'b0, 1, 1'b1);
`ifdef I2C_SLAVE_GCALL_EN
    check("t6_gcall_data", bus.rx_data, 8'h5A);
`else
    check("t6_gcall_ignored", bus.rx_data, 8'h81);
`endif

    // Randomised transactions
    for (int t = 0; t < 30; t++) begin
      sel = $urandom_range(0, 3);
      a = (sel < 2) ? 7'h55 : (sel == 2) ? 7'($urandom_range(0, 127)) : 7'h00;
      rw = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 3);
      for (int k = 0; k < 4; k++) xd[k] = 8'($urandom);
      st = (t == 29) || ($urandom_range(0, 1) == 1);
      do_xfer(a, rw, n, st);
    end

    repeat (10) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
